// File: rtl/bitblade_pkg.sv
// Shared constants, state encoding and precision decode for the bitblade PE sequencer.
package bitblade_pkg;

   localparam int NUM_BB   = 16;
   localparam int SLICE_W  = 2;
   localparam int ELEM_W   = 8;
   localparam int PE_SUM_W = 10;

   localparam logic [1:0] PREC_2B = 2'd0;
   localparam logic [1:0] PREC_4B = 2'd1;
   localparam logic [1:0] PREC_8B = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   // Code 3 is not a distinct precision; it decodes as 8 bits.
   function automatic logic [2:0] prec_to_slices(input logic [1:0] prec);
      case (prec)
         PREC_2B: return 3'd1;
         PREC_4B: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/pe_slice_select.sv
// Picks 2-bit slice number idx out of every 8-bit element and packs the slices onto one bus.
module pe_slice_select
   import bitblade_pkg::*;
(
   input  logic [NUM_BB*ELEM_W-1:0]  vec,
   input  logic [1:0]                idx,
   output logic [NUM_BB*SLICE_W-1:0] slices
);

   for (genvar i = 0; i < NUM_BB; i++) begin : g_bb
      logic [ELEM_W-1:0] elem;
      assign elem = vec[ELEM_W*i +: ELEM_W];
      assign slices[SLICE_W*i +: SLICE_W] = elem[SLICE_W*idx +: SLICE_W];
   end

endmodule

// File: rtl/pe_precision_sequencer.sv
// Walks a fusion-unit PE through all (x-slice, y-slice) pairs of a 16-element dot product
// and shift-accumulates the returned partial sums into a full-precision result.
//
//   state | meaning
//   IDLE  | ready for an operand set
//   ISSUE | one slice pair per cycle to the PE, j inner / k outer
//   DRAIN | PE outputs still in flight, slice buses held at 0
//   DONE  | result presented until the consumer takes it
module pe_precision_sequencer
   import bitblade_pkg::*;
#(
   parameter int PE_LAT = 1,
   parameter int ACC_W  = 21
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_BB*ELEM_W-1:0]    x_vec,
   input  logic [NUM_BB*ELEM_W-1:0]    y_vec,
   input  logic [1:0]                  prec_x,
   input  logic [1:0]                  prec_y,
   input  logic                        signed_x,
   input  logic                        signed_y,
   output logic [NUM_BB*SLICE_W-1:0]   pe_x,
   output logic [NUM_BB*SLICE_W-1:0]   pe_y,
   output logic                        pe_sign_x,
   output logic                        pe_sign_y,
   input  logic [PE_SUM_W-1:0]         pe_sum,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ACC_W-1:0]            out_sum
);

   localparam int CNT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
   localparam int BUS_W = NUM_BB*ELEM_W;
   localparam int PE_W  = NUM_BB*SLICE_W;

   seq_state_e         state_q, state_d;
   logic [BUS_W-1:0]   x_q, y_q;
   logic [1:0]         jmax_q, kmax_q, j_q, k_q;
   logic               sx_q, sy_q;
   logic [CNT_W-1:0]   drain_cnt_q;
   logic [PE_LAT-1:0]  tag_v_q;
   logic [3:0]         tag_sh_q [PE_LAT];
   logic [ACC_W-1:0]   acc_q;

   logic               issue, accept, last_pass;
   logic [PE_W-1:0]    sel_x, sel_y;
   logic [3:0]         shift_now;
   logic [ACC_W-1:0]   addend;

   pe_slice_select u_sel_x (.vec(x_q), .idx(j_q), .slices(sel_x));
   pe_slice_select u_sel_y (.vec(y_q), .idx(k_q), .slices(sel_y));

   assign accept    = in_valid & in_ready;
   assign last_pass = (j_q == jmax_q) && (k_q == kmax_q);
   assign shift_now = {({1'b0, j_q} + {1'b0, k_q}), 1'b0};
   assign addend    = {{(ACC_W-PE_SUM_W){pe_sum[PE_SUM_W-1]}}, pe_sum} << tag_sh_q[PE_LAT-1];

   assign pe_x      = issue ? sel_x : '0;
   assign pe_y      = issue ? sel_y : '0;
   assign pe_sign_x = issue & sx_q & (j_q == jmax_q);
   assign pe_sign_y = issue & sy_q & (k_q == kmax_q);
   assign out_sum   = out_valid ? acc_q : '0;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      issue     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ISSUE;
         end
         ISSUE: begin
            issue = 1'b1;
            if (last_pass) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q         <= '0;
         y_q         <= '0;
         jmax_q      <= '0;
         kmax_q      <= '0;
         j_q         <= '0;
         k_q         <= '0;
         sx_q        <= 1'b0;
         sy_q        <= 1'b0;
         drain_cnt_q <= '0;
         tag_v_q     <= '0;
         acc_q       <= '0;
         for (int s = 0; s < PE_LAT; s++) tag_sh_q[s] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q    <= x_vec;
                  y_q    <= y_vec;
                  jmax_q <= 2'(prec_to_slices(prec_x) - 3'd1);
                  kmax_q <= 2'(prec_to_slices(prec_y) - 3'd1);
                  sx_q   <= signed_x;
                  sy_q   <= signed_y;
                  j_q    <= '0;
                  k_q    <= '0;
               end
            end
            ISSUE: begin
               if (j_q == jmax_q) begin
                  j_q <= '0;
                  k_q <= k_q + 2'd1;
               end else begin
                  j_q <= j_q + 2'd1;
               end
               if (last_pass) drain_cnt_q <= CNT_W'(PE_LAT - 1);
            end
            DRAIN: begin
               if (drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - 1'b1;
            end
            default: ;
         endcase

         // Tags ride alongside the PE register stage so each pe_sum meets its own shift.
         tag_v_q[0]  <= issue;
         tag_sh_q[0] <= issue ? shift_now : 4'd0;
         for (int s = 1; s < PE_LAT; s++) begin
            tag_v_q[s]  <= tag_v_q[s-1];
            tag_sh_q[s] <= tag_sh_q[s-1];
         end

         if (accept)                   acc_q <= '0;
         else if (tag_v_q[PE_LAT-1])   acc_q <= acc_q + addend;
      end
   end

endmodule

// File: tb/tb_pe_precision_sequencer.sv
// Directed bench: a behavioural bitbrick PE closes the loop; results are hand-computed dot products.
module tb_pe_precision_sequencer;

   localparam int PE_LAT = 1;
   localparam int ACC_W  = 21;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [127:0]      x_vec = '0;
   logic [127:0]      y_vec = '0;
   logic [1:0]        prec_x = '0;
   logic [1:0]        prec_y = '0;
   logic              signed_x = 1'b0;
   logic              signed_y = 1'b0;
   logic [31:0]       pe_x, pe_y;
   logic              pe_sign_x, pe_sign_y;
   logic [9:0]        pe_sum = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ACC_W-1:0]  out_sum;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pe_precision_sequencer #(.PE_LAT(PE_LAT), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_vec(x_vec), .y_vec(y_vec),
      .prec_x(prec_x), .prec_y(prec_y),
      .signed_x(signed_x), .signed_y(signed_y),
      .pe_x(pe_x), .pe_y(pe_y),
      .pe_sign_x(pe_sign_x), .pe_sign_y(pe_sign_y),
      .pe_sum(pe_sum),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum)
   );

   // Bitbrick array: 16 signed/unsigned 2x2 multiplies, adder tree, one register stage.
   logic [9:0] pe_comb;
   always_comb begin
      int acc_m;
      int xv, yv;
      acc_m = 0;
      xv = 0;
      yv = 0;
      for (int i = 0; i < 16; i++) begin
         xv = int'(pe_x[2*i +: 2]);
         if (pe_sign_x && pe_x[2*i+1]) xv = xv - 4;
         yv = int'(pe_y[2*i +: 2]);
         if (pe_sign_y && pe_y[2*i+1]) yv = yv - 4;
         acc_m = acc_m + xv*yv;
      end
      pe_comb = 10'(acc_m);
   end

   always @(posedge clk) pe_sum <= pe_comb;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int nslices(input logic [1:0] p);
      return (p == 2'd0) ? 1 : (p == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] rep_slice(input logic [7:0] e, input int idx);
      logic [7:0] t;
      t = e >> (2*idx);
      return {16{t[1:0]}};
   endfunction

   task automatic start_job(input logic [7:0] xe, input logic [7:0] ye,
                            input logic [1:0] px, input logic [1:0] py,
                            input logic sx, input logic sy);
      @(negedge clk);
      x_vec    = {16{xe}};
      y_vec    = {16{ye}};
      prec_x   = px;
      prec_y   = py;
      signed_x = sx;
      signed_y = sy;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // operands must already be captured
      x_vec    = ~x_vec;
      y_vec    = ~y_vec;
   endtask

   task automatic run_job(input string nm, input logic [7:0] xe, input logic [7:0] ye,
                          input logic [1:0] px, input logic [1:0] py,
                          input logic sx, input logic sy,
                          input int exp_sum, input int exp_passes, input int stall);
      int nx, ny, passes, c, j, k;
      logic [ACC_W-1:0] held;
      nx = nslices(px);
      ny = nslices(py);
      passes = nx*ny;
      check_eq({nm, " passes"}, 32'(passes), 32'(exp_passes));
      @(negedge clk);
      check_eq({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
      start_job(xe, ye, px, py, sx, sy);
      for (int p = 0; p < passes; p++) begin
         @(negedge clk);
         j = p % nx;
         k = p / nx;
         check_eq({nm, " pe_x"}, pe_x, rep_slice(xe, j));
         check_eq({nm, " pe_y"}, pe_y, rep_slice(ye, k));
         check_eq({nm, " sign_x"}, 32'(pe_sign_x), 32'(sx && (j == nx-1)));
         check_eq({nm, " sign_y"}, 32'(pe_sign_y), 32'(sy && (k == ny-1)));
         check_eq({nm, " in_ready_busy"}, 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      c = passes + 1;
      check_eq({nm, " drain_bus"}, {pe_x[15:0] | pe_y[15:0], 14'd0, pe_sign_x, pe_sign_y}, 32'd0);
      while (!out_valid && c < passes + 40) begin
         @(negedge clk);
         c++;
      end
      check_eq({nm, " latency"}, 32'(c), 32'(passes + PE_LAT + 1));
      check_eq({nm, " sum"}, 32'($signed(out_sum)), 32'(exp_sum));
      held = out_sum;
      for (int s = 0; s < stall; s++) begin
         if (s == 1) begin
            x_vec    = {16{8'h01}};
            in_valid = 1'b1;
         end
         @(negedge clk);
         in_valid = 1'b0;
         check_eq({nm, " stall_valid"}, 32'(out_valid), 32'd1);
         check_eq({nm, " stall_sum"}, 32'(out_sum), 32'(held));
         check_eq({nm, " stall_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({nm, " post_valid"}, 32'(out_valid), 32'd0);
      check_eq({nm, " post_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_values(input string nm);
      check_eq({nm, " in_ready"}, 32'(in_ready), 32'd1);
      check_eq({nm, " out_valid"}, 32'(out_valid), 32'd0);
      check_eq({nm, " out_sum"}, 32'(out_sum), 32'd0);
      check_eq({nm, " pe_x"}, pe_x, 32'd0);
      check_eq({nm, " pe_y"}, pe_y, 32'd0);
      check_eq({nm, " signs"}, {30'd0, pe_sign_x, pe_sign_y}, 32'd0);
   endtask

   initial begin
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b1;

      run_job("u2x2",   8'd3,   8'd3,   2'd0, 2'd0, 1'b0, 1'b0, 144,     1,  0);
      run_job("u8x8",   8'd255, 8'd255, 2'd2, 2'd2, 1'b0, 1'b0, 1040400, 16, 0);
      run_job("s8x8",   8'h80,  8'h80,  2'd2, 2'd3, 1'b1, 1'b1, 262144,  16, 3);
      run_job("mixed",  8'hFB,  8'd100, 2'd1, 2'd2, 1'b1, 1'b0, -8000,   8,  0);
      run_job("s2x2",   8'h02,  8'h03,  2'd0, 2'd0, 1'b1, 1'b1, 32,      1,  0);

      // abort an 8x8 job in its 5th issue cycle
      start_job(8'd255, 8'd255, 2'd2, 2'd2, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      @(negedge clk);
      check_eq("abort pe_x_before", pe_x, 32'hFFFF_FFFF);
      reset = 1'b0;
      #1;
      check_reset_values("abort");
      @(negedge clk);
      reset = 1'b1;
      run_job("after_abort", 8'd1, 8'd1, 2'd0, 2'd0, 1'b0, 1'b0, 16, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
